// File: rtl/exe_stage.sv
// exe_stage: execute stage of the five-stage MIPS pipeline.
// Single-cycle ALU plus an optional iterative 32-step multiply/divide unit
// writing internal HI/LO registers. The mul/div unit, its FSM and HI/LO are
// built only when the macro EXE_MULDIV_EN is defined; otherwise opcodes
// 12..15 are no-ops, MFHI/MFLO read 0 and stall is tied low.
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validIn,
    input  logic [3:0]       EXE_In,
    input  logic             aluSrcIn,
    input  logic [WIDTH-1:0] readData1In,
    input  logic [WIDTH-1:0] readData2In,
    input  logic [WIDTH-1:0] signExIn,
    output logic [WIDTH-1:0] ALU_Res,
    output logic             zeroOut,
    output logic             stall
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MFHI = 4'd10;
    localparam logic [3:0] OP_MFLO = 4'd11;

    logic [WIDTH-1:0] op_b_s;
    logic [4:0]       shamt_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;
    logic [WIDTH-1:0] alu_res_s;

    assign op_b_s  = aluSrcIn ? signExIn : readData2In;
    assign shamt_s = readData1In[4:0];

`ifdef EXE_MULDIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [1:0]         md_op_r;     // bit1: divide, bit0: unsigned
    logic               neg_a_r;
    logic               neg_b_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [WIDTH-1:0]   work_hi_r;   // partial product high / remainder
    logic [WIDTH-1:0]   work_lo_r;   // multiplier bits / dividend-quotient
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               start_s;
    logic               last_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [WIDTH-1:0]   step_hi_s;
    logic [WIDTH-1:0]   step_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fin_hi_s;
    logic [WIDTH-1:0]   fin_lo_s;

    // Start is masked while reset is held so stall is low during reset.
    assign start_s = rst & validIn & (EXE_In[3:2] == 2'b11) & (state_r == ST_IDLE);
    assign stall   = start_s | (state_r == ST_BUSY);
    assign last_s  = (cnt_r == CNT_LAST);

    assign neg_a_s = ~EXE_In[0] & readData1In[WIDTH-1];
    assign neg_b_s = ~EXE_In[0] & op_b_s[WIDTH-1];
    assign mag_a_s = neg_a_s ? -readData1In : readData1In;
    assign mag_b_s = neg_b_s ? -op_b_s : op_b_s;

    assign hi_s = hi_r;
    assign lo_s = lo_r;

    // One shift-add (mul) or restoring-subtract (div) iteration on magnitudes.
    always_comb begin
        mul_sum_s   = {(WIDTH+1){1'b0}};
        div_shift_s = {work_hi_r, work_lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mag_b_r};
        step_hi_s   = work_hi_r;
        step_lo_s   = work_lo_r;
        if (md_op_r[1]) begin
            // No borrow means the shifted remainder covers the divisor.
            if (!div_diff_s[WIDTH]) begin
                step_hi_s = div_diff_s[WIDTH-1:0];
                step_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[WIDTH-1:0];
                step_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            mul_sum_s = {1'b0, work_hi_r} +
                        (work_lo_r[0] ? {1'b0, mag_b_r} : {(WIDTH+1){1'b0}});
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the final step; divide by zero gives LO all ones, HI = A.
    always_comb begin
        prod_s   = {step_hi_s, step_lo_s};
        fin_hi_s = step_hi_s;
        fin_lo_s = step_lo_s;
        if (md_op_r[1]) begin
            fin_hi_s = neg_a_r ? -step_hi_s : step_hi_s;
            if (mag_b_r == {WIDTH{1'b0}}) begin
                fin_lo_s = {WIDTH{1'b1}};
            end else begin
                fin_lo_s = (neg_a_r ^ neg_b_r) ? -step_lo_s : step_lo_s;
            end
        end else begin
            if (neg_a_r ^ neg_b_r) begin
                {fin_hi_s, fin_lo_s} = -prod_s;
            end else begin
                {fin_hi_s, fin_lo_s} = prod_s;
            end
        end
    end

    // FSM next state: DONE lasts one cycle so the held instruction never restarts.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture at acceptance, iteration, and HI/LO write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= {CW{1'b0}};
            md_op_r   <= 2'b00;
            neg_a_r   <= 1'b0;
            neg_b_r   <= 1'b0;
            mag_b_r   <= {WIDTH{1'b0}};
            work_hi_r <= {WIDTH{1'b0}};
            work_lo_r <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        cnt_r     <= {CW{1'b0}};
                        md_op_r   <= EXE_In[1:0];
                        neg_a_r   <= neg_a_s;
                        neg_b_r   <= neg_b_s;
                        mag_b_r   <= mag_b_s;
                        work_hi_r <= {WIDTH{1'b0}};
                        work_lo_r <= mag_a_s;
                    end
                end
                ST_BUSY: begin
                    cnt_r     <= cnt_r + CNT_ONE;
                    work_hi_r <= step_hi_s;
                    work_lo_r <= step_lo_s;
                    if (last_s) begin
                        hi_r <= fin_hi_s;
                        lo_r <= fin_lo_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic unused_s;

    assign unused_s = &{1'b0, clk, rst, validIn};
    assign stall    = 1'b0;
    assign hi_s     = {WIDTH{1'b0}};
    assign lo_s     = {WIDTH{1'b0}};
`endif

    // Combinational ALU; mul/div opcodes return zero.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (EXE_In)
            OP_ADD:  alu_res_s = readData1In + op_b_s;
            OP_SUB:  alu_res_s = readData1In - op_b_s;
            OP_AND:  alu_res_s = readData1In & op_b_s;
            OP_OR:   alu_res_s = readData1In | op_b_s;
            OP_XOR:  alu_res_s = readData1In ^ op_b_s;
            OP_NOR:  alu_res_s = ~(readData1In | op_b_s);
            OP_SLT: begin
                if ($signed(readData1In) < $signed(op_b_s)) begin
                    alu_res_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    alu_res_s = {WIDTH{1'b0}};
                end
            end
            OP_SLL:  alu_res_s = op_b_s << shamt_s;
            OP_SRL:  alu_res_s = op_b_s >> shamt_s;
            OP_SRA:  alu_res_s = $signed(op_b_s) >>> shamt_s;
            OP_MFHI: alu_res_s = hi_s;
            OP_MFLO: alu_res_s = lo_s;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign ALU_Res = alu_res_s;
    assign zeroOut = (alu_res_s == {WIDTH{1'b0}});

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed table-driven bench for exe_stage plus hand-written
// multi-cycle sequences for the mul/div unit (only when EXE_MULDIV_EN is set).
module tb_exe_stage;
    localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  AND_ = 4'd2, OR_ = 4'd3;
    localparam logic [3:0] XOR_ = 4'd4, NOR_ = 4'd5, SLT = 4'd6,  SLL = 4'd7;
    localparam logic [3:0] SRL = 4'd8,  SRA = 4'd9,  MFHI = 4'd10, MFLO = 4'd11;
    localparam logic [3:0] MULT = 4'd12, MULTU = 4'd13, DIV = 4'd14, DIVU = 4'd15;

    logic        clk = 1'b0;
    logic        rst;
    logic        validIn;
    logic [3:0]  EXE_In;
    logic        aluSrcIn;
    logic [31:0] readData1In, readData2In, signExIn;
    logic [31:0] ALU_Res;
    logic        zeroOut;
    logic        stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic        src;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[19];

    exe_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .validIn(validIn), .EXE_In(EXE_In),
        .aluSrcIn(aluSrcIn), .readData1In(readData1In), .readData2In(readData2In),
        .signExIn(signExIn), .ALU_Res(ALU_Res), .zeroOut(zeroOut), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic src,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        validIn = v; EXE_In = op; aluSrcIn = src;
        readData1In = a; readData2In = b; signExIn = imm;
    endtask

    // Present one instruction for one cycle and return ALU_Res mid-cycle.
    task automatic rd(input logic [3:0] op, output logic [31:0] r);
        @(posedge clk); #1;
        drive(1'b1, op, 1'b0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        r = ALU_Res;
    endtask

    // Issue a mul/div held until stall drops; returns the stall length.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        n = 0;
        @(posedge clk); #1;
        drive(1'b1, op, 1'b0, a, b, 32'h0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n == 1) chk("md_res_zero", ALU_Res, 32'h0);
            // Operands have been captured; later changes must be ignored.
            if (n >= 2) begin
                readData1In = $urandom;
                readData2In = $urandom;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        int n;

        vecs[0]  = '{1'b1, ADD,   1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h80000000, 1'b0};
        vecs[1]  = '{1'b1, SUB,   1'b0, 32'h00000005, 32'h00000005, 32'h0, 32'h00000000, 1'b1};
        vecs[2]  = '{1'b1, SLT,   1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000001, 1'b0};
        vecs[3]  = '{1'b1, SLT,   1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h00000000, 1'b1};
        vecs[4]  = '{1'b1, SRA,   1'b0, 32'h00000004, 32'h80000000, 32'h0, 32'hF8000000, 1'b0};
        vecs[5]  = '{1'b1, SRL,   1'b0, 32'h00000004, 32'h80000000, 32'h0, 32'h08000000, 1'b0};
        vecs[6]  = '{1'b1, SRL,   1'b0, 32'h00000024, 32'h80000000, 32'h0, 32'h08000000, 1'b0};
        vecs[7]  = '{1'b1, SLL,   1'b0, 32'h00000008, 32'h000000FF, 32'h0, 32'h0000FF00, 1'b0};
        vecs[8]  = '{1'b1, AND_,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 1'b0};
        vecs[9]  = '{1'b1, OR_,   1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hFFF0FFF0, 1'b0};
        vecs[10] = '{1'b1, XOR_,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0FF00FF0, 1'b0};
        vecs[11] = '{1'b1, NOR_,  1'b0, 32'h00000000, 32'h00000000, 32'h0, 32'hFFFFFFFF, 1'b0};
        vecs[12] = '{1'b1, ADD,   1'b1, 32'h00000010, 32'h00001000, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
        vecs[13] = '{1'b1, SUB,   1'b1, 32'h00000003, 32'h00001000, 32'h00000005, 32'hFFFFFFFE, 1'b0};
        vecs[14] = '{1'b0, ADD,   1'b0, 32'h00000002, 32'h00000003, 32'h0, 32'h00000005, 1'b0};
        vecs[15] = '{1'b0, MULTU, 1'b0, 32'h00000002, 32'h00000003, 32'h0, 32'h00000000, 1'b1};
        vecs[16] = '{1'b0, DIV,   1'b0, 32'h00000009, 32'h00000003, 32'h0, 32'h00000000, 1'b1};
        vecs[17] = '{1'b1, MFHI,  1'b0, 32'h00000000, 32'h00000000, 32'h0, 32'h00000000, 1'b1};
        vecs[18] = '{1'b1, MFLO,  1'b0, 32'h00000000, 32'h00000000, 32'h0, 32'h00000000, 1'b1};

        rst = 1'b0;
        drive(1'b0, ADD, 1'b0, 32'h0, 32'h0, 32'h0);
        #2;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_res", ALU_Res, 32'h0);
        chk("rst_zero", {31'h0, zeroOut}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].valid, vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].imm);
            @(negedge clk);
            chk($sformatf("vec%0d_res", i), ALU_Res, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), {31'h0, zeroOut}, {31'h0, vecs[i].zero});
            chk($sformatf("vec%0d_stall", i), {31'h0, stall}, 32'h0);
        end

`ifdef EXE_MULDIV_EN
        run_md(MULT, 32'hFFFFFFFD, 32'h00000007, n);
        chk("mult_stall_len", n, 32'd33);
        rd(MFLO, r); chk("mult_lo", r, 32'hFFFFFFEB);
        rd(MFHI, r); chk("mult_hi", r, 32'hFFFFFFFF);

        run_md(DIV, 32'hFFFFFFF9, 32'h00000002, n);
        chk("div_stall_len", n, 32'd33);
        rd(MFLO, r); chk("div_lo", r, 32'hFFFFFFFD);
        rd(MFHI, r); chk("div_hi", r, 32'hFFFFFFFF);

        run_md(DIV, 32'h00000007, 32'hFFFFFFFE, n);
        rd(MFLO, r); chk("div_negb_lo", r, 32'hFFFFFFFD);
        rd(MFHI, r); chk("div_negb_hi", r, 32'h00000001);

        run_md(DIVU, 32'h00000007, 32'h00000000, n);
        rd(MFLO, r); chk("divu0_lo", r, 32'hFFFFFFFF);
        rd(MFHI, r); chk("divu0_hi", r, 32'h00000007);

        run_md(DIV, 32'hFFFFFFF9, 32'h00000000, n);
        rd(MFLO, r); chk("div0_lo", r, 32'hFFFFFFFF);
        rd(MFHI, r); chk("div0_hi", r, 32'hFFFFFFF9);

        run_md(DIV, 32'h80000000, 32'hFFFFFFFF, n);
        rd(MFLO, r); chk("divmin_lo", r, 32'h80000000);
        rd(MFHI, r); chk("divmin_hi", r, 32'h00000000);

        run_md(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        rd(MFLO, r); chk("multu_max_lo", r, 32'h00000001);
        rd(MFHI, r); chk("multu_max_hi", r, 32'hFFFFFFFE);

        // Bubble mul/div must not stall nor touch HI/LO.
        @(posedge clk); #1;
        drive(1'b0, MULTU, 1'b0, 32'h00000002, 32'h00000003, 32'h0);
        @(negedge clk); chk("bubble_stall", {31'h0, stall}, 32'h0);
        @(negedge clk); chk("bubble_stall2", {31'h0, stall}, 32'h0);
        rd(MFLO, r); chk("bubble_lo", r, 32'h00000001);

        // Back-to-back: DONE cycle separates two full stalls.
        run_md(MULTU, 32'd2, 32'd3, n);
        chk("b2b_first_len", n, 32'd33);
        run_md(MULTU, 32'd4, 32'd5, n);
        chk("b2b_second_len", n, 32'd33);
        rd(MFLO, r); chk("b2b_lo", r, 32'd20);
        rd(MFHI, r); chk("b2b_hi", r, 32'd0);

        // Reset during step 10 of a DIV.
        @(posedge clk); #1;
        drive(1'b1, DIV, 1'b0, 32'd100, 32'd7, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_stall", {31'h0, stall}, 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", {31'h0, stall}, 32'h0);
        drive(1'b0, ADD, 1'b0, 32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", {31'h0, stall}, 32'h0);
        rd(MFHI, r); chk("post_rst_hi", r, 32'h0);
        rd(MFLO, r); chk("post_rst_lo", r, 32'h0);
        run_md(MULT, 32'd6, 32'd7, n);
        chk("post_rst_len", n, 32'd33);
        rd(MFLO, r); chk("post_rst_mult_lo", r, 32'd42);
        rd(MFHI, r); chk("post_rst_mult_hi", r, 32'd0);
`else
        @(posedge clk); #1;
        drive(1'b1, MULT, 1'b0, 32'd6, 32'd7, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("nomd_stall", {31'h0, stall}, 32'h0);
            chk("nomd_res", ALU_Res, 32'h0);
        end
        rd(MFLO, r); chk("nomd_lo", r, 32'h0);
        rd(MFHI, r); chk("nomd_hi", r, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
